// File: rtl/radio_rx_en_seq.sv
// Multi-channel radio receive-enable sequencer: per-channel warm-up delay before
// enabling radioRxEn and a minimum on-time before releasing it, with an isolation clamp.
module radio_rx_en_seq #(
    parameter int NCH = 4,
    parameter int CW  = 8
) (
    input  logic              ck,
    input  logic              arst,
    input  logic              isolateM1M3,
    input  logic [NCH-1:0]    radioRxEnSynced,
    input  logic [CW-1:0]     warmDly,
    input  logic [CW-1:0]     minOn,
    output logic [NCH-1:0]    radioRxEn,
    output logic [NCH-1:0]    rxBusy,
    output logic [NCH-1:0]    reqDropped,
    output logic              anyRxEn,
    output logic [2*NCH-1:0]  dbgState
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WARM = 2'd1,
        S_ON   = 2'd2
    } state_t;

    state_t          r_state     [NCH];
    state_t          w_state_nxt [NCH];
    logic [CW-1:0]   r_cnt       [NCH];
    logic [CW-1:0]   w_cnt_nxt   [NCH];
    logic [NCH-1:0]  w_req;
    logic [NCH-1:0]  w_drop_nxt;
    logic [NCH-1:0]  r_rx_en;
    logic [NCH-1:0]  r_busy;
    logic [NCH-1:0]  r_drop;

    assign w_req = radioRxEnSynced & {NCH{~isolateM1M3}};

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_drop_nxt[i]  = 1'b0;
            case (r_state[i])
                S_IDLE: begin
                    if (w_req[i]) begin
                        if (warmDly == '0) begin
                            w_state_nxt[i] = S_ON;
                            w_cnt_nxt[i]   = minOn;
                        end else begin
                            w_state_nxt[i] = S_WARM;
                            w_cnt_nxt[i]   = warmDly - CW'(1);
                        end
                    end
                end
                S_WARM: begin
                    // A lost request wins over a warm-up that would complete this cycle.
                    if (!w_req[i]) begin
                        w_state_nxt[i] = S_IDLE;
                        w_cnt_nxt[i]   = '0;
                        w_drop_nxt[i]  = 1'b1;
                    end else if (r_cnt[i] == '0) begin
                        w_state_nxt[i] = S_ON;
                        w_cnt_nxt[i]   = minOn;
                    end else begin
                        w_cnt_nxt[i]   = r_cnt[i] - CW'(1);
                    end
                end
                S_ON: begin
                    if (!w_req[i] && (r_cnt[i] <= CW'(1))) begin
                        w_state_nxt[i] = S_IDLE;
                        w_cnt_nxt[i]   = '0;
                    end else if (r_cnt[i] != '0) begin
                        w_cnt_nxt[i]   = r_cnt[i] - CW'(1);
                    end
                end
                default: begin
                    w_state_nxt[i] = S_IDLE;
                    w_cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (arst) begin
            for (int i = 0; i < NCH; i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
            end
            r_rx_en <= '0;
            r_busy  <= '0;
            r_drop  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
                r_rx_en[i] <= (w_state_nxt[i] == S_ON);
                r_busy[i]  <= (w_state_nxt[i] != S_IDLE);
            end
            r_drop <= w_drop_nxt;
        end
    end

    always_comb begin
        dbgState = '0;
        for (int i = 0; i < NCH; i++) begin
            dbgState[2*i +: 2] = r_state[i];
        end
    end

    assign radioRxEn  = r_rx_en;
    assign rxBusy     = r_busy;
    assign reqDropped = r_drop;
    assign anyRxEn    = |r_rx_en;

endmodule

// File: tb/tb_radio_rx_en_seq.sv
// Directed bench for radio_rx_en_seq: reset, warm-up latency, minimum on-time,
// abort, isolation, channel independence and reset while all channels are on.
module tb_radio_rx_en_seq;

  localparam int NCH = 4;
  localparam int CW  = 8;

  logic             ck;
  logic             arst;
  logic             isolateM1M3;
  logic [NCH-1:0]   req;
  logic [CW-1:0]    warmDly;
  logic [CW-1:0]    minOn;
  logic [NCH-1:0]   radioRxEn;
  logic [NCH-1:0]   rxBusy;
  logic [NCH-1:0]   reqDropped;
  logic             anyRxEn;
  logic [2*NCH-1:0] dbgState;

  int n_checks = 0;
  int n_errors = 0;

  radio_rx_en_seq #(.NCH(NCH), .CW(CW)) dut (
    .ck              (ck),
    .arst            (arst),
    .isolateM1M3     (isolateM1M3),
    .radioRxEnSynced (req),
    .warmDly         (warmDly),
    .minOn           (minOn),
    .radioRxEn       (radioRxEn),
    .rxBusy          (rxBusy),
    .reqDropped      (reqDropped),
    .anyRxEn         (anyRxEn),
    .dbgState        (dbgState)
  );

  // clock / reset
  initial ck = 1'b0;
  always #5 ck = ~ck;

  // driver tasks
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [NCH-1:0] en,
                            input logic [NCH-1:0] busy, input logic [NCH-1:0] drop);
    check_eq({tag, ".en"},   32'(radioRxEn),  32'(en));
    check_eq({tag, ".busy"}, 32'(rxBusy),     32'(busy));
    check_eq({tag, ".drop"}, 32'(reqDropped), 32'(drop));
    check_eq({tag, ".any"},  32'(anyRxEn),    32'(|en));
  endtask

  // Holds ch0 request for 'hold' edges, then counts further high cycles until release.
  task automatic measure_high(input int hold, output int n);
    n = 0;
    req[0] = 1'b1;
    for (int k = 0; k < hold; k++) begin
      tick();
      if (radioRxEn[0]) n++;
    end
    req[0] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (radioRxEn[0]) n++;
      else break;
    end
  endtask

  int n_high;

  initial begin
    arst = 1'b1;
    isolateM1M3 = 1'b0;
    req = '0;
    warmDly = '0;
    minOn = '0;

    // reset with random requests
    for (int k = 0; k < 3; k++) begin
      req = NCH'($urandom_range(0, (1 << NCH) - 1));
      tick();
    end
    check_outs("rst", 4'b0000, 4'b0000, 4'b0000);
    check_eq("rst.state", 32'(dbgState), 32'd0);
    arst = 1'b0;
    req = '0;
    for (int k = 0; k < 3; k++) tick();
    check_outs("idle", 4'b0000, 4'b0000, 4'b0000);

    // warm-up latency 5
    warmDly = 8'd5;
    minOn = 8'd0;
    req = 4'b0001;
    tick();
    check_outs("warm5.t", 4'b0000, 4'b0001, 4'b0000);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_outs($sformatf("warm5.t%0d", k), 4'b0000, 4'b0001, 4'b0000);
    end
    tick();
    check_outs("warm5.t5", 4'b0001, 4'b0001, 4'b0000);
    req = '0;
    tick();
    check_outs("warm5.rel", 4'b0000, 4'b0000, 4'b0000);

    // warm-up latency 0
    warmDly = 8'd0;
    req = 4'b0001;
    tick();
    check_outs("warm0.t", 4'b0001, 4'b0001, 4'b0000);
    req = '0;
    tick();
    check_outs("warm0.rel", 4'b0000, 4'b0000, 4'b0000);

    // minimum on-time
    minOn = 8'd4;
    measure_high(1, n_high);
    check_eq("minon4.pulse1", 32'(n_high), 32'd4);
    minOn = 8'd1;
    measure_high(1, n_high);
    check_eq("minon1.pulse1", 32'(n_high), 32'd1);
    measure_high(10, n_high);
    check_eq("minon1.req10", 32'(n_high), 32'd10);
    check_outs("minon.after", 4'b0000, 4'b0000, 4'b0000);

    // maximum warm-up delay, no wrap
    warmDly = 8'd255;
    minOn = 8'd0;
    req = 4'b0001;
    tick();
    n_high = 0;
    while (!radioRxEn[0] && n_high < 300) begin
      tick();
      n_high++;
    end
    check_eq("warm255.lat", 32'(n_high), 32'd255);
    req = '0;
    tick();
    check_outs("warm255.rel", 4'b0000, 4'b0000, 4'b0000);

    // abort during warm-up
    warmDly = 8'd8;
    req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_outs($sformatf("abort.w%0d", k), 4'b0000, 4'b0001, 4'b0000);
    end
    req = '0;
    tick();
    check_outs("abort.edge", 4'b0000, 4'b0000, 4'b0001);
    check_eq("abort.state", 32'(dbgState[1:0]), 32'd0);
    tick();
    check_outs("abort.next", 4'b0000, 4'b0000, 4'b0000);

    // isolation: ch2 warming (loaded with 10), ch1 on with minOn=6
    warmDly = 8'd10;
    minOn = 8'd6;
    req = 4'b0100;
    tick();
    warmDly = 8'd0;
    req = 4'b0110;
    tick();
    check_outs("iso.t", 4'b0010, 4'b0110, 4'b0000);
    tick();
    check_outs("iso.t1", 4'b0010, 4'b0110, 4'b0000);
    isolateM1M3 = 1'b1;
    tick();
    check_outs("iso.t2", 4'b0010, 4'b0010, 4'b0100);
    for (int k = 3; k <= 5; k++) begin
      tick();
      check_outs($sformatf("iso.t%0d", k), 4'b0010, 4'b0010, 4'b0000);
    end
    tick();
    check_outs("iso.t6", 4'b0000, 4'b0000, 4'b0000);
    isolateM1M3 = 1'b0;
    req = '0;
    tick();

    // staggered channels, warmDly=3
    warmDly = 8'd3;
    minOn = 8'd2;
    req = 4'b0001; tick(); check_outs("stag.a0", 4'b0000, 4'b0001, 4'b0000);
    req = 4'b1001; tick(); check_outs("stag.a1", 4'b0000, 4'b1001, 4'b0000);
    req = 4'b1011; tick(); check_outs("stag.a2", 4'b0000, 4'b1011, 4'b0000);
    req = 4'b1111; tick(); check_outs("stag.a3", 4'b0001, 4'b1111, 4'b0000);
    tick(); check_outs("stag.a4", 4'b1001, 4'b1111, 4'b0000);
    tick(); check_outs("stag.a5", 4'b1011, 4'b1111, 4'b0000);
    tick(); check_outs("stag.a6", 4'b1111, 4'b1111, 4'b0000);
    check_eq("stag.state", 32'(dbgState), 32'h0000_00AA);

    // reset while all channels are on
    arst = 1'b1;
    tick();
    check_outs("rston", 4'b0000, 4'b0000, 4'b0000);
    check_eq("rston.state", 32'(dbgState), 32'd0);
    arst = 1'b0;
    req = '0;
    tick();
    check_outs("rston.next", 4'b0000, 4'b0000, 4'b0000);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
